// File: rtl/wb_stage_pkg.sv
// Shared widths, reset constants and payload type for the write-back stage.
package wb_stage_pkg;

  localparam int XLEN  = 32;
  localparam int WE_W  = 4;
  localparam int REG_W = 5;
  localparam int WT_W  = 3;

  localparam logic [XLEN-1:0]  ini_wb_PC         = 32'hBFC0_0000;
  localparam logic [XLEN-1:0]  ini_wb_wdata      = '0;
  localparam logic [WE_W-1:0]  ini_wb_we         = '0;
  localparam logic [REG_W-1:0] ini_wb_wnum       = '0;
  localparam logic [WT_W-1:0]  ini_wb_write_type = '0;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  wdata;
    logic [WE_W-1:0]  we;
    logic [REG_W-1:0] wnum;
    logic [WT_W-1:0]  write_type;
  } wb_payload_t;

  // Register $0 is hard-wired to zero, so its byte enables are always dropped.
  function automatic logic [WE_W-1:0] rf_mask(input logic [WE_W-1:0] we,
                                               input logic [REG_W-1:0] wnum);
    return (wnum == '0) ? '0 : we;
  endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Free-running count of retired instructions; wraps silently at all-ones.
module wb_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches the memory-stage result, retires it to the register
// file and debug trace under trace back-pressure, and exposes bypass data.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = ini_wb_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_in,
  output logic             wb_allowin_out,
  input  logic [31:0]      mem_wbdata_in,
  input  logic [3:0]       mem_reg_we_in,
  input  logic [31:0]      mem_PC_in,
  input  logic [4:0]       mem_wnum_in,
  input  logic [2:0]       mem_write_type_in,
  input  logic             trace_ready_in,
  output logic [3:0]       rf_we_out,
  output logic [4:0]       rf_wnum_out,
  output logic [31:0]      rf_wdata_out,
  output logic             fwd_valid_out,
  output logic [3:0]       fwd_we_out,
  output logic [4:0]       fwd_wnum_out,
  output logic [31:0]      fwd_wdata_out,
  output logic [2:0]       fwd_write_type_out,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retire_cnt_out
);

  logic        valid_reg;
  wb_payload_t payload_reg;
  wb_payload_t payload_next;
  logic        ready;
  logic        retire;

  assign ready          = trace_ready_in;
  assign wb_allowin_out = !valid_reg || ready;
  assign retire         = valid_reg && ready;

  assign payload_next = '{pc:         mem_PC_in,
                          wdata:      mem_wbdata_in,
                          we:         mem_reg_we_in,
                          wnum:       mem_wnum_in,
                          write_type: mem_write_type_in};

  // A bubble only clears valid; the stale payload is masked everywhere by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      payload_reg <= '{pc:         PC_RESET,
                       wdata:      ini_wb_wdata,
                       we:         ini_wb_we,
                       wnum:       ini_wb_wnum,
                       write_type: ini_wb_write_type};
    end else if (wb_allowin_out) begin
      valid_reg <= mem_valid_in;
      if (mem_valid_in)
        payload_reg <= payload_next;
    end
  end

  assign rf_we_out    = retire ? rf_mask(payload_reg.we, payload_reg.wnum) : 4'b0;
  assign rf_wnum_out  = payload_reg.wnum;
  assign rf_wdata_out = payload_reg.wdata;

  assign debug_wb_pc       = payload_reg.pc;
  assign debug_wb_rf_wen   = rf_we_out;
  assign debug_wb_rf_wnum  = payload_reg.wnum;
  assign debug_wb_rf_wdata = payload_reg.wdata;

  assign fwd_valid_out      = valid_reg;
  assign fwd_we_out         = valid_reg ? payload_reg.we : 4'b0;
  assign fwd_wnum_out       = payload_reg.wnum;
  assign fwd_wdata_out      = payload_reg.wdata;
  assign fwd_write_type_out = payload_reg.write_type;

  wb_retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk (clk),
    .rst (rst),
    .en  (retire),
    .cnt (retire_cnt_out)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected retire records,
// a negedge monitor pops and compares them whenever an instruction retires.
module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_valid_in;
  logic             wb_allowin_out;
  logic [31:0]      mem_wbdata_in;
  logic [3:0]       mem_reg_we_in;
  logic [31:0]      mem_PC_in;
  logic [4:0]       mem_wnum_in;
  logic [2:0]       mem_write_type_in;
  logic             trace_ready_in;
  logic [3:0]       rf_we_out;
  logic [4:0]       rf_wnum_out;
  logic [31:0]      rf_wdata_out;
  logic             fwd_valid_out;
  logic [3:0]       fwd_we_out;
  logic [4:0]       fwd_wnum_out;
  logic [31:0]      fwd_wdata_out;
  logic [2:0]       fwd_write_type_out;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;
  logic [CNT_W-1:0] retire_cnt_out;

  wb_stage #(.PC_RESET(32'hBFC0_0000), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_in       (mem_valid_in),
    .wb_allowin_out     (wb_allowin_out),
    .mem_wbdata_in      (mem_wbdata_in),
    .mem_reg_we_in      (mem_reg_we_in),
    .mem_PC_in          (mem_PC_in),
    .mem_wnum_in        (mem_wnum_in),
    .mem_write_type_in  (mem_write_type_in),
    .trace_ready_in     (trace_ready_in),
    .rf_we_out          (rf_we_out),
    .rf_wnum_out        (rf_wnum_out),
    .rf_wdata_out       (rf_wdata_out),
    .fwd_valid_out      (fwd_valid_out),
    .fwd_we_out         (fwd_we_out),
    .fwd_wnum_out       (fwd_wnum_out),
    .fwd_wdata_out      (fwd_wdata_out),
    .fwd_write_type_out (fwd_write_type_out),
    .debug_wb_pc        (debug_wb_pc),
    .debug_wb_rf_wen    (debug_wb_rf_wen),
    .debug_wb_rf_wnum   (debug_wb_rf_wnum),
    .debug_wb_rf_wdata  (debug_wb_rf_wdata),
    .retire_cnt_out     (retire_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one instruction and hold it until the stage accepts it.
  task automatic send(input logic [31:0] pc, input logic [4:0] wnum,
                      input logic [31:0] data, input logic [3:0] we);
    exp_t e;
    bit   acc;
    int   n;
    mem_valid_in      = 1'b1;
    mem_PC_in         = pc;
    mem_wnum_in       = wnum;
    mem_wbdata_in     = data;
    mem_reg_we_in     = we;
    mem_write_type_in = 3'(wnum);
    e.pc = pc; e.wen = (wnum == 5'd0) ? 4'h0 : we; e.wnum = wnum; e.wdata = data;
    exp_q.push_back(e);
    $display("send pc=0x%08h wnum=%0d data=0x%08h we=0x%h", pc, wnum, data, we);
    n = 0;
    do begin
      @(negedge clk);
      acc = wb_allowin_out;
      @(posedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_accept_timeout", 32'(acc), 32'd1);
    #1;
  endtask

  task automatic idle();
    mem_valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every retire against the scoreboard and tracks the counter.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (!done) begin
      chk("retire_cnt", 32'(retire_cnt_out), 32'(exp_cnt % 16));
      if (fwd_valid_out && trace_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: pc=0x%08h wen=0x%h, scoreboard empty", debug_wb_pc, debug_wb_rf_wen);
        end else begin
          e = exp_q.pop_front();
          $display("retire pc=0x%08h wen=0x%h wnum=%0d data=0x%08h", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
          chk("trace_pc",    debug_wb_pc,              e.pc);
          chk("trace_wen",   32'(debug_wb_rf_wen),     32'(e.wen));
          chk("trace_wnum",  32'(debug_wb_rf_wnum),    32'(e.wnum));
          chk("trace_wdata", debug_wb_rf_wdata,        e.wdata);
          chk("rf_we",       32'(rf_we_out),           32'(e.wen));
          chk("rf_wnum",     32'(rf_wnum_out),         32'(e.wnum));
          chk("rf_wdata",    rf_wdata_out,             e.wdata);
        end
        exp_cnt++;
      end else begin
        chk("rf_we_idle", 32'(rf_we_out), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid_in = 1'b0; trace_ready_in = 1'b1;
    mem_PC_in = '0; mem_wnum_in = '0; mem_wbdata_in = '0;
    mem_reg_we_in = '0; mem_write_type_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    $display("check reset state");
    chk("reset_rf_we",   32'(rf_we_out),      32'd0);
    chk("reset_pc",      debug_wb_pc,         32'hBFC0_0000);
    chk("reset_cnt",     32'(retire_cnt_out), 32'd0);
    chk("reset_allowin", 32'(wb_allowin_out), 32'd1);
    chk("reset_fwd_v",   32'(fwd_valid_out),  32'd0);
    @(posedge clk); #1;

    // Single retire, partial write, $0 suppression
    send(32'hBFC0_0010, 5'd5, 32'h1234_5678, 4'hF);
    send(32'hBFC0_0014, 5'd8, 32'hCAFE_BABE, 4'b0011);
    send(32'hBFC0_0018, 5'd0, 32'hDEAD_BEEF, 4'hF);
    send(32'hBFC0_001C, 5'd9, 32'h0000_0001, 4'h0);
    idle(); idle();
    @(negedge clk);
    chk("cnt_after_four", 32'(retire_cnt_out), 32'd4);
    @(posedge clk); #1;

    // Stall: held instruction stays bypassable, next one waits upstream
    trace_ready_in = 1'b0;
    send(32'hBFC0_0100, 5'd3, 32'hAAAA_0003, 4'hF);
    mem_valid_in = 1'b1; mem_PC_in = 32'hBFC0_0104; mem_wnum_in = 5'd4;
    mem_wbdata_in = 32'hBBBB_0004; mem_reg_we_in = 4'hF;
    exp_q.push_back('{pc: 32'hBFC0_0104, wen: 4'hF, wnum: 5'd4, wdata: 32'hBBBB_0004});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_allowin", 32'(wb_allowin_out), 32'd0);
      chk("stall_fwd_v",   32'(fwd_valid_out),  32'd1);
      chk("stall_fwd_we",  32'(fwd_we_out),     32'hF);
      chk("stall_pc",      debug_wb_pc,         32'hBFC0_0100);
      @(posedge clk);
    end
    #1 trace_ready_in = 1'b1;
    @(negedge clk);
    chk("unstall_allowin", 32'(wb_allowin_out), 32'd1);
    @(posedge clk); #1;
    mem_valid_in = 1'b0;
    @(negedge clk);
    chk("next_latched_pc",  debug_wb_pc,          32'hBFC0_0104);
    chk("next_latched_fwd", 32'(fwd_wnum_out),    32'd4);
    @(posedge clk); #1;
    idle();

    // Reset in mid-stall discards the held instruction
    trace_ready_in = 1'b0;
    send(32'hBFC0_0200, 5'd7, 32'h7777_7777, 4'hF);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    trace_ready_in = 1'b1;
    @(negedge clk);
    chk("rst_stall_fwd_v", 32'(fwd_valid_out),  32'd0);
    chk("rst_stall_cnt",   32'(retire_cnt_out), 32'd0);
    chk("rst_stall_rf_we", 32'(rf_we_out),      32'd0);
    @(posedge clk); #1;

    // Counter wrap: 16 retires with one bubble in the stream
    for (int i = 0; i < 16; i++) begin
      send(32'hBFC0_1000 + 32'(i * 4), 5'(i + 1), 32'h5A00_0000 + 32'(i), 4'(i + 1));
      if (i == 7) begin
        mem_valid_in = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_fwd_v", 32'(fwd_valid_out), 32'd0);
        chk("bubble_rf_we", 32'(rf_we_out),     32'd0);
        @(posedge clk); #1;
      end
    end
    idle(); idle();
    @(negedge clk);
    chk("wrap_cnt", 32'(retire_cnt_out), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of the memory stage.
- Latches the memory stage's result (data, byte write enables, PC, destination register, write type) into a pipeline register.
- Retires the instruction: drives the register-file write port and the debug trace port, and exposes bypass/hazard information to decode.
- Supports trace back-pressure through a ready/allowin handshake and counts retired instructions.

Parameters:
- PC_RESET, 32'hBFC0_0000, value of the latched PC after reset
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mem_valid_in  in  1  memory stage holds a valid instruction
- wb_allowin_out  out  1  wb can accept a new instruction this cycle
- mem_wbdata_in  in  32  write-back data
- mem_reg_we_in  in  4  per-byte register write enables (partial for lwl/lwr)
- mem_PC_in  in  32  instruction PC
- mem_wnum_in  in  5  destination register number
- mem_write_type_in  in  3  write-type tag; passed through unchanged
- trace_ready_in  in  1  debug trace consumer accepts a retire this cycle
- rf_we_out  out  4  register-file byte write enables
- rf_wnum_out  out  5  register-file write address
- rf_wdata_out  out  32  register-file write data
- fwd_valid_out  out  1  wb holds a valid instruction (bypass candidate)
- fwd_we_out  out  4  byte enables of held instruction
- fwd_wnum_out  out  5  destination of held instruction
- fwd_wdata_out  out  32  data of held instruction
- fwd_write_type_out  out  3  write type of held instruction
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_wen  out  4  retiring byte enables
- debug_wb_rf_wnum  out  5  retiring register number
- debug_wb_rf_wdata  out  32  retiring data
- retire_cnt_out  out  CNT_W  number of instructions retired since reset

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - valid_r=0, PC_r=PC_RESET, wdata_r=0, we_r=0, wnum_r=0, write_type_r=0, retire counter=0.
  - Consequently all rf_*, debug_* enables and fwd_valid_out are 0.
  - Reset overrides a simultaneous load.
- ready = trace_ready_in.
- wb_allowin_out = !valid_r || ready.
- retire = valid_r && ready.
- Pipeline register update at posedge clk:
  - if wb_allowin_out: valid_r <= mem_valid_in.
  - if wb_allowin_out && mem_valid_in: all payload registers load from the mem_*_in inputs.
  - else: payload and valid_r hold.
  - A bubble entering (allowin, !mem_valid_in) clears valid_r but leaves the payload stale. The payload must never be observed when valid_r=0.
- Latency: one cycle from memory-stage output to retire when trace_ready_in=1.
- Register-file write:
  - rf_we_out = retire ? we_r : 4'b0.
  - Forced to 0 when wnum_r==0, so $0 is never written.
  - rf_wnum_out = wnum_r and rf_wdata_out = wdata_r unconditionally.
  - Exactly one write per instruction, even if it is stalled for many cycles.
- Debug trace:
  - debug_wb_pc = PC_r.
  - debug_wb_rf_wen = rf_we_out.
  - debug_wb_rf_wnum = wnum_r.
  - debug_wb_rf_wdata = wdata_r.
  - A trace record is emitted only in retire cycles. Instructions with we_r=0 still retire, with wen=0.
- Bypass:
  - fwd_valid_out = valid_r. This stays asserted while stalled, so decode can still bypass from it.
  - fwd_we_out = valid_r ? we_r : 0.
  - fwd_wnum, fwd_wdata and fwd_write_type are driven straight from the registers.
- Retire counter: increments by 1 on each retire cycle and wraps from all-ones to 0 silently.
- Back-pressure:
  - trace_ready_in=0 with valid_r=1 holds the instruction, drives wb_allowin_out=0, and produces no rf write.
  - Upstream must keep its outputs stable while wb_allowin_out=0.
- Simultaneous retire and load: when valid_r && ready && mem_valid_in, the old instruction retires and the new one latches at the same edge. Sustained throughput is 1 instruction per cycle.
- Reset in mid-stall: the held instruction is discarded; no write occurs and the counter does not increment.

Decomposition:
- Shared defines.vh gets ini_wb_PC, ini_wb_wdata, ini_wb_we, ini_wb_wnum and ini_wb_write_type reset constants, alongside the existing ini_* constants.
- The retire counter is natural as sub-module wb_retire_counter (enable, wrap, CNT_W parameter).
- Everything else stays flat.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then mem_valid_in=0 → rf_we_out=0, debug_wb_pc=32'hBFC0_0000, retire_cnt_out=0, wb_allowin_out=1.
- Single retire: mem_valid_in=1 with PC=0xBFC00010, wnum=5, data=0x12345678, we=4'hF, trace_ready=1 → next cycle rf_we_out=F, rf_wnum_out=5, rf_wdata_out=0x12345678, debug_wb_pc=0xBFC00010, retire_cnt_out=1 one cycle later.
- Partial write: we=4'b0011, wnum=8 → rf_we_out=4'b0011 for exactly one cycle.
- $0 suppression: wnum=0, we=F → rf_we_out=0, but the instruction still retires and retire_cnt_out increments.
- Stall: trace_ready_in=0 for 3 cycles with a valid instruction held → wb_allowin_out=0, rf_we_out=0, fwd_valid_out=1 throughout; after trace_ready_in rises, exactly one write occurs and the next instruction latches at the same edge.
- Counter wrap (CNT_W=4): 16 back-to-back retires → retire_cnt_out reads 0 after the 16th; one bubble in the stream → valid_r=0 and no write in the bubble cycle.
